// File: rtl/mioc_dma_initiator_if.sv
// MIOC handshake and DRAM bus seen by the 6801-side DMA initiator.
// The master modport is the initiator; the slave modport is the MIOC/DRAM side.
interface mioc_dma_initiator_if;
    logic        DMA_N;
    logic        ADDRBUFEN_N;
    logic        OS3_N;
    logic        IS3_N;
    logic [15:0] DA;
    logic [7:0]  DQ_OUT;
    logic [7:0]  DQ_IN;
    logic        DMREQ_N;
    logic        DWR_N;
    logic        DRD_N;

    modport master (
        output DMA_N, OS3_N, DA, DQ_OUT, DMREQ_N, DWR_N, DRD_N,
        input  ADDRBUFEN_N, IS3_N, DQ_IN
    );

    modport slave (
        input  DMA_N, OS3_N, DA, DQ_OUT, DMREQ_N, DWR_N, DRD_N,
        output ADDRBUFEN_N, IS3_N, DQ_IN
    );
endinterface

// File: rtl/mioc_dma_initiator.sv
// 6801-side DMA master: requests the Z80 bus from the MIOC, moves a block of
// bytes between a byte stream and DRAM, then releases and notifies completion.
module mioc_dma_initiator #(
    parameter int unsigned GRANT_TIMEOUT = 255
) (
    input  logic                        B_PHI,
    input  logic                        RST_N,
    mioc_dma_initiator_if.master        bus,
    input  logic                        START,
    input  logic                        DIR,
    input  logic [15:0]                 START_ADDR,
    input  logic [7:0]                  LEN,
    input  logic [7:0]                  SRC_DATA,
    input  logic                        SRC_VALID,
    output logic                        SRC_READY,
    output logic [7:0]                  SNK_DATA,
    output logic                        SNK_VALID,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERR
);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, STROBE, RECOV, RELEASE, NOTIFY, WAITACK
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(GRANT_TIMEOUT - 1);

    state_t      state, state_n;
    logic [1:0]  gnt_sync;
    logic [1:0]  ack_sync;
    logic        dir_q;
    logic [15:0] addr;
    logic [7:0]  cnt;
    logic [7:0]  timer;
    logic        strb_2nd;
    logic [7:0]  dq_out;
    logic [7:0]  sample;
    logic        err;
    logic        done;

    logic        dma_n, os3_n, dmreq_n, dwr_n, drd_n;
    logic        src_ready, snk_valid;
    logic        grant_lost;
    logic        ack_low;

    assign grant_lost = gnt_sync[1];
    assign ack_low    = ~ack_sync[1];

    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            state    <= IDLE;
            gnt_sync <= '1;
            ack_sync <= '1;
            dir_q    <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            timer    <= '0;
            strb_2nd <= 1'b0;
            dq_out   <= '0;
            sample   <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            gnt_sync <= {gnt_sync[0], bus.ADDRBUFEN_N};
            ack_sync <= {ack_sync[0], bus.IS3_N};
            done     <= (state == WAITACK) && !ack_low;
            strb_2nd <= (state == STROBE) && !strb_2nd;
            case (state)
                IDLE: begin
                    if (START) begin
                        dir_q <= DIR;
                        addr  <= START_ADDR;
                        cnt   <= LEN;
                        timer <= '0;
                        err   <= 1'b0;
                    end
                end
                REQ: begin
                    timer <= timer + 8'd1;
                    if (grant_lost && timer == TIMER_LAST) err <= 1'b1;
                end
                ADDR: begin
                    if (grant_lost) err <= 1'b1;
                    else if (dir_q && SRC_VALID) dq_out <= SRC_DATA;
                end
                STROBE: begin
                    if (grant_lost) err <= 1'b1;
                    else if (strb_2nd && !dir_q) sample <= bus.DQ_IN;
                end
                RECOV: begin
                    // an aborted byte leaves address and count untouched
                    if (grant_lost) err <= 1'b1;
                    else begin
                        addr <= addr + 16'd1;
                        cnt  <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        dma_n     = 1'b1;
        os3_n     = 1'b1;
        dmreq_n   = 1'b1;
        dwr_n     = 1'b1;
        drd_n     = 1'b1;
        src_ready = 1'b0;
        snk_valid = 1'b0;
        case (state)
            IDLE: begin
                if (START) state_n = REQ;
            end
            REQ: begin
                dma_n = 1'b0;
                if (!grant_lost) state_n = ADDR;
                else if (timer == TIMER_LAST) state_n = RELEASE;
            end
            ADDR: begin
                dma_n = 1'b0;
                if (grant_lost) state_n = RELEASE;
                else if (dir_q) begin
                    // the memory request only goes out once the byte is in hand
                    src_ready = 1'b1;
                    if (SRC_VALID) begin
                        dmreq_n = 1'b0;
                        state_n = STROBE;
                    end
                end else begin
                    dmreq_n = 1'b0;
                    state_n = STROBE;
                end
            end
            STROBE: begin
                dma_n   = 1'b0;
                dmreq_n = 1'b0;
                if (dir_q) dwr_n = 1'b0;
                else       drd_n = 1'b0;
                if (grant_lost) state_n = RELEASE;
                else if (strb_2nd) state_n = RECOV;
            end
            RECOV: begin
                dma_n     = 1'b0;
                snk_valid = !dir_q && !grant_lost;
                if (grant_lost || cnt == 8'd1) state_n = RELEASE;
                else state_n = ADDR;
            end
            RELEASE: begin
                if (grant_lost) state_n = err ? IDLE : NOTIFY;
            end
            NOTIFY: begin
                os3_n = 1'b0;
                if (ack_low) state_n = WAITACK;
            end
            WAITACK: begin
                if (!ack_low) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.DMA_N   = dma_n;
    assign bus.OS3_N   = os3_n;
    assign bus.DMREQ_N = dmreq_n;
    assign bus.DWR_N   = dwr_n;
    assign bus.DRD_N   = drd_n;
    assign bus.DA      = addr;
    assign bus.DQ_OUT  = dq_out;
    assign SRC_READY   = src_ready;
    assign SNK_DATA    = sample;
    assign SNK_VALID   = snk_valid;
    assign BUSY        = (state != IDLE);
    assign DONE        = done;
    assign ERR         = err;

endmodule

// File: tb/tb_mioc_dma_initiator.sv
// Scoreboard bench for mioc_dma_initiator: transaction-level expectations are
// queued at issue time and checked by independent bus/stream monitors.
module tb_mioc_dma_initiator;

    localparam int unsigned TO = 10;

    logic        B_PHI = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        DIR = 1'b0;
    logic [15:0] START_ADDR = '0;
    logic [7:0]  LEN = '0;
    logic [7:0]  SRC_DATA = '0;
    logic        SRC_VALID = 1'b0;
    logic        SRC_READY;
    logic [7:0]  SNK_DATA;
    logic        SNK_VALID;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    always #5 B_PHI = ~B_PHI;

    mioc_dma_initiator_if bus ();

    mioc_dma_initiator #(.GRANT_TIMEOUT(TO)) dut (
        .B_PHI      (B_PHI),
        .RST_N      (RST_N),
        .bus        (bus),
        .START      (START),
        .DIR        (DIR),
        .START_ADDR (START_ADDR),
        .LEN        (LEN),
        .SRC_DATA   (SRC_DATA),
        .SRC_VALID  (SRC_VALID),
        .SRC_READY  (SRC_READY),
        .SNK_DATA   (SNK_DATA),
        .SNK_VALID  (SNK_VALID),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ERR        (ERR)
    );

    // DRAM model: only drives real data while the read strobe is low
    logic [7:0] mem [65536];
    assign bus.DQ_IN = bus.DRD_N ? 8'hEE : mem[bus.DA];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard queues
    logic [23:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic        done_q [$];

    // transaction stimulus tables
    logic [7:0] t_bytes [256];
    int         t_gaps  [256];
    bit         last_err = 1'b0;

    int dma_low_cnt = 0;
    int os3_low_cnt = 0;

    // write strobe monitor
    logic prev_dwr = 1'b1;
    int   dwr_w = 0;
    always @(negedge B_PHI) begin
        logic [23:0] e;
        if (!bus.DWR_N) begin
            if (prev_dwr) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got DA=%h DQ=%h expected no write", bus.DA, bus.DQ_OUT);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", bus.DA, e[23:8]);
                    chk("wr_data", bus.DQ_OUT, e[7:0]);
                    chk("wr_dmreq", bus.DMREQ_N, 0);
                end
            end
            dwr_w++;
        end else if (!prev_dwr) begin
            chk("wr_width", dwr_w, 2);
            dwr_w = 0;
        end
        prev_dwr = bus.DWR_N;
    end

    // read strobe and sink monitor
    logic prev_drd = 1'b1;
    logic prev_snk = 1'b0;
    int   drd_w = 0;
    always @(negedge B_PHI) begin
        if (!bus.DRD_N) drd_w++;
        else if (!prev_drd) begin
            chk("rd_width", drd_w, 2);
            drd_w = 0;
        end
        prev_drd = bus.DRD_N;
        if (SNK_VALID) begin
            chk("snk_pulse", prev_snk, 0);
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snk_unexpected: got %h expected no byte", SNK_DATA);
            end else chk("snk_data", SNK_DATA, rd_q.pop_front());
        end
        prev_snk = SNK_VALID;
    end

    // completion monitor and cycle counters
    always @(negedge B_PHI) begin
        if (!bus.DMA_N) dma_low_cnt++;
        if (!bus.OS3_N) os3_low_cnt++;
        if (DONE) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got DONE=1 expected 0");
            end else chk("done_err", ERR, done_q.pop_front());
        end
    end

    // byte source: gaps count only cycles in which the DUT is asking for data
    logic [7:0] src_q [$];
    int         gap_q [$];
    bit         hs_pending = 1'b0;
    always @(negedge B_PHI) begin
        if (hs_pending) begin
            src_q.delete(0);
            gap_q.delete(0);
            hs_pending = 1'b0;
        end
        if (src_q.size() > 0 && gap_q[0] == 0) begin
            SRC_VALID = 1'b1;
            SRC_DATA  = src_q[0];
        end else begin
            SRC_VALID = 1'b0;
            SRC_DATA  = 8'($urandom);
        end
        #1;
        if (SRC_READY) begin
            if (SRC_VALID) hs_pending = 1'b1;
            else if (src_q.size() > 0) begin
                gap_q[0]--;
                chk("stall_dmreq", bus.DMREQ_N, 1);
                chk("stall_dwr", bus.DWR_N, 1);
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_dma_n"}, bus.DMA_N, 1);
        chk({tag, "_os3_n"}, bus.OS3_N, 1);
        chk({tag, "_dmreq_n"}, bus.DMREQ_N, 1);
        chk({tag, "_dwr_n"}, bus.DWR_N, 1);
        chk({tag, "_drd_n"}, bus.DRD_N, 1);
        chk({tag, "_da"}, bus.DA, 0);
        chk({tag, "_dq_out"}, bus.DQ_OUT, 0);
        chk({tag, "_src_ready"}, SRC_READY, 0);
        chk({tag, "_snk_valid"}, SNK_VALID, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    task automatic fill_bytes(input int len, input int maxgap);
        for (int i = 0; i < len; i++) begin
            t_bytes[i] = 8'($urandom);
            t_gaps[i]  = int'($urandom_range(0, maxgap));
        end
    endtask

    // One block transfer with the MIOC side played by this task.
    task automatic run_txn(input bit dir, input logic [15:0] addr, input int len,
                           input int gdelay, input bit no_grant, input int abort_k,
                           input bit rst_notify, input bit spurious);
        int          n_exp;
        int          stalls;
        int          t;
        int          cnt;
        bit          exp_err;
        logic        prev;
        logic [15:0] a;

        exp_err = no_grant || (abort_k > 0);
        n_exp   = no_grant ? 0 : (abort_k > 0 ? abort_k : len);
        stalls  = 0;
        for (int i = 0; i < n_exp; i++) begin
            a = addr + 16'(i);
            if (dir) begin
                wr_q.push_back({a, t_bytes[i]});
                stalls += t_gaps[i];
            end else rd_q.push_back(mem[a]);
        end
        if (!exp_err && !rst_notify) done_q.push_back(1'b0);
        if (dir) begin
            for (int i = 0; i < len; i++) begin
                src_q.push_back(t_bytes[i]);
                gap_q.push_back(t_gaps[i]);
            end
        end

        chk("err_hold", ERR, last_err);
        @(negedge B_PHI);
        START = 1'b1;
        DIR = dir;
        START_ADDR = addr;
        LEN = 8'(len);
        dma_low_cnt = 0;
        os3_low_cnt = 0;
        @(negedge B_PHI);
        START = 1'b0;
        START_ADDR = 16'($urandom);
        chk("req_dma_n", bus.DMA_N, 0);
        chk("req_busy", BUSY, 1);
        chk("req_err_clr", ERR, 0);
        chk("req_da", bus.DA, addr);

        if (spurious) begin
            fork
                begin
                    repeat (6) @(negedge B_PHI);
                    START = 1'b1;
                    DIR = ~dir;
                    START_ADDR = 16'($urandom);
                    LEN = 8'($urandom);
                    @(negedge B_PHI);
                    START = 1'b0;
                end
            join_none
        end

        if (no_grant) begin
            t = 0;
            while (!bus.DMA_N && t < 400) begin
                @(negedge B_PHI);
                t++;
            end
            chk("timeout_len", dma_low_cnt, TO);
        end else begin
            repeat (gdelay) @(negedge B_PHI);
            bus.ADDRBUFEN_N = 1'b0;
            if (abort_k > 0) begin
                cnt = 0;
                t = 0;
                prev = 1'b1;
                while (cnt < abort_k && t < 3000) begin
                    @(negedge B_PHI);
                    if (!bus.DWR_N && prev) cnt++;
                    prev = bus.DWR_N;
                    t++;
                end
                chk("abort_reached", cnt, abort_k);
                bus.ADDRBUFEN_N = 1'b1;
                repeat (3) @(negedge B_PHI);
                chk("abort_dma_n", bus.DMA_N, 1);
                chk("abort_dwr_n", bus.DWR_N, 1);
                chk("abort_dmreq_n", bus.DMREQ_N, 1);
            end else begin
                t = 0;
                while (!bus.DMA_N && t < 3000) begin
                    @(negedge B_PHI);
                    t++;
                end
                chk("dma_low_len", dma_low_cnt, 3 + gdelay + 4 * len + stalls);
                repeat ($urandom_range(0, 3)) @(negedge B_PHI);
                bus.ADDRBUFEN_N = 1'b1;
                t = 0;
                while (bus.OS3_N && t < 50) begin
                    @(negedge B_PHI);
                    t++;
                end
                chk("os3_assert", bus.OS3_N, 0);
                if (rst_notify) begin
                    repeat (2) @(negedge B_PHI);
                    RST_N = 1'b0;
                    @(negedge B_PHI);
                    check_reset_outs("midrst");
                    RST_N = 1'b1;
                end else begin
                    repeat ($urandom_range(0, 4)) @(negedge B_PHI);
                    bus.IS3_N = 1'b0;
                    t = 0;
                    do begin
                        @(negedge B_PHI);
                        t++;
                    end while (!bus.OS3_N && t < 20);
                    chk("os3_release_lat", t, 3);
                    repeat ($urandom_range(0, 4)) @(negedge B_PHI);
                    bus.IS3_N = 1'b1;
                    t = 0;
                    do begin
                        @(negedge B_PHI);
                        t++;
                    end while (!DONE && t < 20);
                    chk("done_lat", t, 3);
                end
            end
        end

        t = 0;
        while (BUSY && t < 200) begin
            @(negedge B_PHI);
            t++;
        end
        chk("idle", BUSY, 0);
        repeat (2) @(negedge B_PHI);
        chk("err_final", ERR, exp_err && !rst_notify);
        if (exp_err) chk("no_os3", os3_low_cnt, 0);
        chk("wr_left", wr_q.size(), 0);
        chk("rd_left", rd_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        src_q.delete();
        gap_q.delete();
        hs_pending = 1'b0;
        last_err = exp_err && !rst_notify;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdir;
        logic [15:0] raddr;
        int          rlen;

        bus.ADDRBUFEN_N = 1'b1;
        bus.IS3_N = 1'b1;
        RST_N = 1'b0;
        repeat (3) @(negedge B_PHI);
        check_reset_outs("reset");
        RST_N = 1'b1;
        @(negedge B_PHI);

        t_bytes[0] = 8'hA1; t_bytes[1] = 8'hB2; t_bytes[2] = 8'hC3;
        t_gaps[0] = 0; t_gaps[1] = 0; t_gaps[2] = 0;
        run_txn(1'b1, 16'h7FFE, 3, 5, 1'b0, 0, 1'b0, 1'b0);

        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'h6B;
        run_txn(1'b0, 16'hFFFF, 2, int'($urandom_range(0, 6)), 1'b0, 0, 1'b0, 1'b0);

        fill_bytes(256, 0);
        run_txn(1'b1, 16'($urandom), 256, 0, 1'b0, 0, 1'b0, 1'b0);

        fill_bytes(4, 0);
        run_txn(1'b1, 16'($urandom), 4, 0, 1'b1, 0, 1'b0, 1'b0);

        fill_bytes(4, 0);
        t_gaps[1] = 3;
        run_txn(1'b1, 16'($urandom), 4, 2, 1'b0, 0, 1'b0, 1'b1);

        fill_bytes(5, 0);
        run_txn(1'b1, 16'($urandom), 5, 1, 1'b0, 2, 1'b0, 1'b0);

        fill_bytes(2, 0);
        run_txn(1'b1, 16'($urandom), 2, 0, 1'b0, 0, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rdir  = 1'($urandom);
            raddr = 16'($urandom);
            rlen  = int'($urandom_range(1, 8));
            if (rdir) fill_bytes(rlen, 2);
            else begin
                for (int i = 0; i < rlen; i++) mem[raddr + 16'(i)] = 8'($urandom);
            end
            run_txn(rdir, raddr, rlen, int'($urandom_range(0, 6)), 1'b0, 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
